// File: rtl/i2c_pkg.sv
// Shared constants for the I2C byte-level master: command codes,
// FSM state encoding and quarter-period indices.
package i2c_pkg;

    // Command codes presented on cmd
    localparam logic [1:0] I2C_CMD_START = 2'd0;
    localparam logic [1:0] I2C_CMD_STOP  = 2'd1;
    localparam logic [1:0] I2C_CMD_WRITE = 2'd2;
    localparam logic [1:0] I2C_CMD_READ  = 2'd3;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_STOP  = 3'd2;
    localparam logic [2:0] ST_XFER  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Quarter indices within one bit / one START or STOP
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // Bit index of the ACK slot in a byte transfer
    localparam logic [3:0] ACK_BIT = 4'd8;

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period prescaler: counts CLK_DIV clk cycles and emits a
// registered one-cycle tick at each wrap. Held at zero while disabled
// or restarting; freeze stalls the count (used for SCL clock stretching).
module i2c_quarter_timer #(
    parameter int unsigned CLK_DIV = 64
) (
    input  logic clk,
    input  logic nreset,
    input  logic restart,
    input  logic enable,
    input  logic freeze,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler count with wrap at CLK_DIV-1; tick registered on wrap
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (restart || !enable) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (freeze) begin
            tick <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/i2c_master_ctl.sv
// Byte-level I2C master sequencer: START / STOP / WRITE / READ commands
// through a valid/ready handshake, SCL/SDA generated in quarter periods.
// Optional feature macro: I2C_CLOCK_STRETCH_EN (prescaler freezes while a
// released SCL is held low by a slave).
module i2c_master_ctl
    import i2c_pkg::*;
#(
    parameter int unsigned CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_wdata,
    input  logic       cmd_ack,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       scl,
    output logic       sda,
    input  logic       scl_in,
    input  logic       sda_in
);

    logic [2:0] state;
    logic [1:0] q;
    logic [3:0] bitcnt;
    logic [7:0] shreg;
    logic [1:0] cmd_r;
    logic       ack_r;
    logic       tick;
    logic       accept;
    logic       active;
    logic       freeze;

    assign cmd_ready = (state == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign active    = (state == ST_START) || (state == ST_STOP) || (state == ST_XFER);

`ifdef I2C_CLOCK_STRETCH_EN
    // Released SCL still seen low: a slave is stretching the clock
    assign freeze = scl && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign freeze        = 1'b0;
`endif

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .nreset  (nreset),
        .restart (accept),
        .enable  (active),
        .freeze  (freeze),
        .tick    (tick)
    );

    // Command FSM; pin levels are registered and updated on quarter entry
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            q         <= Q0;
            bitcnt    <= '0;
            shreg     <= '0;
            cmd_r     <= I2C_CMD_START;
            ack_r     <= 1'b0;
            scl       <= 1'b1;
            sda       <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_r  <= cmd;
                        ack_r  <= cmd_ack;
                        shreg  <= cmd_wdata;
                        q      <= Q0;
                        bitcnt <= '0;
                        scl    <= 1'b0;
                        case (cmd)
                            I2C_CMD_START: begin
                                state <= ST_START;
                                sda   <= 1'b1;
                            end
                            I2C_CMD_STOP: begin
                                state <= ST_STOP;
                                sda   <= 1'b0;
                            end
                            I2C_CMD_WRITE: begin
                                state <= ST_XFER;
                                sda   <= cmd_wdata[7];
                            end
                            default: begin
                                state <= ST_XFER;
                                sda   <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_START: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            Q0: scl <= 1'b1;
                            Q1: sda <= 1'b0;
                            Q2: scl <= 1'b0;
                            default: begin
                                state     <= ST_DONE;
                                rsp_valid <= 1'b1;
                                rsp_nack  <= 1'b0;
                                busy      <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            Q0: scl <= 1'b1;
                            Q1: sda <= 1'b1;
                            Q2: ;
                            default: begin
                                state     <= ST_DONE;
                                rsp_valid <= 1'b1;
                                rsp_nack  <= 1'b0;
                                busy      <= 1'b0;
                            end
                        endcase
                    end
                end
                ST_XFER: begin
                    if (tick) begin
                        q <= q + 2'd1;
                        case (q)
                            Q0: ;
                            Q1: scl <= 1'b1;
                            Q2: ;
                            default: begin
                                // End of bit: sample on the last cycle of the high phase
                                scl <= 1'b0;
                                if (bitcnt == ACK_BIT) begin
                                    state     <= ST_DONE;
                                    rsp_valid <= 1'b1;
                                    if (cmd_r == I2C_CMD_WRITE) begin
                                        rsp_nack <= sda_in;
                                    end else begin
                                        rsp_nack  <= 1'b0;
                                        rsp_rdata <= shreg;
                                    end
                                end else begin
                                    shreg  <= {shreg[6:0], sda_in};
                                    bitcnt <= bitcnt + 4'd1;
                                    if (bitcnt == 4'd7)
                                        sda <= (cmd_r == I2C_CMD_WRITE) ? 1'b1 : ack_r;
                                    else
                                        sda <= (cmd_r == I2C_CMD_WRITE) ? shreg[6] : 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_ctl.sv
// Directed bench for i2c_master_ctl with CLK_DIV=4 and a simple bus model
// (open-drain wired-AND of master and slave, optional SCL stretch).
module tb_i2c_master_ctl;

    localparam int DIV = 4;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam int STRETCH = 20;
`else
    localparam int STRETCH = 0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ack = 1'b0;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, scl, sda;
    logic [7:0] rsp_rdata;
    logic       scl_in, sda_in;
    logic       slave_sda = 1'b1;
    logic       stretch = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    assign scl_in = scl & ~stretch;
    assign sda_in = sda & slave_sda;

    always #5 clk = ~clk;

    i2c_master_ctl #(.CLK_DIV(DIV)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd       (cmd),
        .cmd_wdata (cmd_wdata),
        .cmd_ack   (cmd_ack),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .scl       (scl),
        .sda       (sda),
        .scl_in    (scl_in),
        .sda_in    (sda_in)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it to rsp_valid. Cycle c counts clk edges
    // after the accept edge (edge 0); sampling happens on negedges.
    // pat: bus level the slave presents for bits 0..8 (MSB first).
    // stretch_rise: index of the SCL rise at which the slave holds SCL low 20 cycles.
    task automatic run_cmd(input logic [1:0] c_code, input logic [7:0] wd, input logic ack,
                           input logic [8:0] pat, input int stretch_rise,
                           output int lat, output logic [8:0] cap,
                           output int scl_fall, output int sda_fall);
        int   rises;
        int   left;
        logic pscl, psda;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c_code;
        cmd_wdata = wd;
        cmd_ack   = ack;
        slave_sda = pat[8];
        pscl = scl;
        psda = sda;
        lat = -1; cap = '0; rises = 0; left = 0; scl_fall = -1; sda_fall = -1;
        for (int c = 0; c < 2000 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 0) begin
                // Inputs are don't-care after accept
                cmd_valid = 1'b0;
                cmd       = ~c_code;
                cmd_wdata = ~wd;
                cmd_ack   = ~ack;
            end
            if (left > 0) begin
                left--;
                if (left == 0) stretch = 1'b0;
            end
            if (!pscl && scl) begin
                cap = {cap[7:0], sda_in};
                if (rises == stretch_rise) begin
                    stretch = 1'b1;
                    left    = 20;
                end
                rises++;
            end
            if (pscl && !scl) begin
                scl_fall = c;
                if (rises >= 1 && rises <= 8) slave_sda = pat[8 - rises];
            end
            if (psda && !sda) sda_fall = c;
            pscl = scl;
            psda = sda;
            if (rsp_valid) lat = c;
        end
        slave_sda = 1'b1;
        stretch   = 1'b0;
    endtask

    initial begin
        int         lat, sf, df, seen, ready_seen;
        logic [8:0] cap;

        // Reset state
        #23;
        check("rst_scl", scl, 1'b1);
        check("rst_sda", sda, 1'b1);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 8'h00);
        check("rst_rsp_nack", rsp_nack, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        nreset = 1'b1;

        // START from released bus
        run_cmd(2'd0, 8'h00, 1'b0, 9'h1FF, -1, lat, cap, sf, df);
        check("start_lat", lat, 17);
        check("start_sda_fall", df, 9);
        check("start_scl_fall", sf, 13);
        check("start_busy", busy, 1'b1);
        check("start_scl_end", scl, 1'b0);
        check("start_sda_end", sda, 1'b0);
        check("start_ready_in_done", cmd_ready, 1'b0);
        check("start_nack", rsp_nack, 1'b0);
        @(negedge clk);
        check("start_rsp_pulse", rsp_valid, 1'b0);
        check("start_ready_after", cmd_ready, 1'b1);

        // WRITE 0xA5, slave ACKs
        run_cmd(2'd2, 8'hA5, 1'b0, 9'h1FE, -1, lat, cap, sf, df);
        check("wr_ack_lat", lat, 145);
        check("wr_ack_bits", cap, 9'h14A);
        check("wr_ack_nack", rsp_nack, 1'b0);
        check("wr_ack_scl_end", scl, 1'b0);

        // WRITE 0xA5, no slave
        run_cmd(2'd2, 8'hA5, 1'b0, 9'h1FF, -1, lat, cap, sf, df);
        check("wr_noack_lat", lat, 145);
        check("wr_noack_bits", cap, 9'h14B);
        check("wr_noack_nack", rsp_nack, 1'b1);

        // READ 0x3C, master NACKs
        run_cmd(2'd3, 8'h00, 1'b1, {8'h3C, 1'b1}, -1, lat, cap, sf, df);
        check("rd_lat", lat, 145);
        check("rd_bus_bits", cap, {8'h3C, 1'b1});
        check("rd_data", rsp_rdata, 8'h3C);
        check("rd_nack", rsp_nack, 1'b0);
        check("rd_sda_end", sda, 1'b1);

        // WRITE 0x5A with slave stretching SCL during bit 3 high phase
        run_cmd(2'd2, 8'h5A, 1'b0, 9'h1FE, 3, lat, cap, sf, df);
        check("stretch_lat", lat, 145 + STRETCH);
        check("stretch_bits", cap, 9'h0B4);
        check("stretch_nack", rsp_nack, 1'b0);
        check("stretch_rdata_held", rsp_rdata, 8'h3C);

        // READ interrupted by reset during the ACK bit (master drives SDA low)
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 2'd3;
        cmd_ack   = 1'b0;
        for (int c = 0; c < 132; c++) begin
            @(negedge clk);
            if (c == 0) cmd_valid = 1'b0;
        end
        check("rdrst_scl_before", scl, 1'b0);
        check("rdrst_sda_before", sda, 1'b0);
        #2 nreset = 1'b0;
        #1;
        check("rdrst_scl", scl, 1'b1);
        check("rdrst_sda", sda, 1'b1);
        check("rdrst_ready", cmd_ready, 1'b1);
        check("rdrst_busy", busy, 1'b0);
        check("rdrst_rdata", rsp_rdata, 8'h00);
        @(negedge clk);
        nreset = 1'b1;
        seen = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("rdrst_no_rsp", seen, 0);

        // STOP with cmd_valid held, then START queued behind it
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 2'd1;
        lat = -1;
        ready_seen = 0;
        for (int c = 0; c < 200 && lat < 0; c++) begin
            @(negedge clk);
            if (rsp_valid) lat = c;
            else if (cmd_ready) ready_seen++;
        end
        check("stop_lat", lat, 17);
        check("stop_ready_low", ready_seen, 0);
        check("stop_ready_in_done", cmd_ready, 1'b0);
        check("stop_busy", busy, 1'b0);
        check("stop_scl", scl, 1'b1);
        check("stop_sda", sda, 1'b1);
        cmd = 2'd0;
        @(negedge clk);
        check("b2b_ready_idle", cmd_ready, 1'b1);
        @(negedge clk);
        check("b2b_accepted", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        lat = -1;
        for (int k = 1; k < 200 && lat < 0; k++) begin
            @(negedge clk);
            if (rsp_valid) lat = k;
        end
        check("b2b_start_lat", lat, 17);
        check("b2b_start_busy", busy, 1'b1);

        // Final STOP releases the bus
        run_cmd(2'd1, 8'h00, 1'b0, 9'h1FF, -1, lat, cap, sf, df);
        check("stop2_lat", lat, 17);
        check("stop2_busy", busy, 1'b0);
        check("stop2_scl", scl, 1'b1);
        check("stop2_sda", sda, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
